sz_quant_select: RTL
====================

# sz_quant_select

Downstream stage of the 2nd-order prediction model in the SZ first-stage pipeline. Consumes the model's prediction and absolute error, aligns them with the original sample and its valid flag, and classifies each point against the error bound. It emits a 2-bit code and the reconstructed value, which is the value fed back as the next `proceed` history. Unpredictable raw samples go into a small FIFO for the outlier writer.

## Interface
Parameters:
- `FLOAT_W`, 32: IEEE-754 single width.
- `MODEL_LAT`, 36: cycles from `data_in` presentation to valid model `error`/`data_out`.
- `UNP_DEPTH`, 16: unpredictable-FIFO depth, power of two, ≥2.

Ports:
- `clk` in 1: single clock domain.
- `rst` in 1: reset, asynchronous and active-low.
- `clear` in 1: synchronous; zeroes counters and `overflow`.
- `in_valid` in 1: asserted in the cycle the sample is presented to the model's `data_in`.
- `data_in` in FLOAT_W: original sample, same cycle as `in_valid`.
- `pred` in FLOAT_W: model `data_out`.
- `err_abs` in FLOAT_W: model `error`, |prediction − original|.
- `err_bound` in FLOAT_W: positive finite bound, quasi-static.
- `code_valid` out 1: code/recon strobe.
- `code` out 2: 01 predictable, 00 unpredictable, 10/11 reserved (never driven).
- `recon` out FLOAT_W: `pred` if predictable, else original sample.
- `unp_valid` out 1 / `unp_ready` in 1 / `unp_data` out FLOAT_W: FIFO read port, ready/valid.
- `overflow` out 1: sticky; push attempted while FIFO full.
- `n_points` out 32, `n_unp` out 32: saturating counters.

## Operation
- Alignment: delay `in_valid` and `data_in` by exactly `MODEL_LAT` cycles. The delay line holds `MODEL_LAT` entries, is free-running, and has no stall path.
- Compare in the aligned cycle, on magnitude bits `[FLOAT_W-2:0]` as unsigned. Sign bits are ignored.
- The point is predictable iff `err_abs[30:0] < err_bound[30:0]` (strict) AND the `err_abs` exponent is not all ones. NaN and Inf are therefore always unpredictable.
- Register stage produces `code`, `recon`, and `code_valid`.
- Unpredictable point: push the original sample into the FIFO at the same edge.
- Push while full (without a simultaneous pop): data dropped, `overflow` set and held until `clear` or reset.
- `n_points` increments per `code_valid`. `n_unp` increments per unpredictable point, dropped ones included. Both saturate at 0xFFFFFFFF.
- `clear` coinciding with an increment: clear wins; the count that cycle is lost.
- The code stream has no backpressure. Only the outlier path is flow-controlled.

## Timing
- Reset (async assert, sync release): `code_valid`=0, `code`=00, `recon`=0, `unp_valid`=0, `unp_data`=0, `overflow`=0, counters=0. The delay line's valid bits are cleared and the FIFO is emptied.
- Reset mid-stream: in-flight points are discarded; no `code_valid` appears for points whose `in_valid` preceded reset release.
- Latency: `code_valid` is high exactly `MODEL_LAT+1` cycles after `in_valid`. Throughput is 1 point/cycle.
- FIFO push/read timing:
  - `unp_valid` rises the cycle after a push into an empty FIFO; there is no bypass.
  - Pop occurs when `unp_valid && unp_ready`.
  - `unp_data` is stable while `unp_valid && !unp_ready`.
- Simultaneous push and pop when full: both happen, no overflow.
- Simultaneous push and pop when empty: only the push happens.
- Pointers wrap modulo `UNP_DEPTH`. Full/empty are distinguished by an extra pointer bit.

## Structure
- Shared package `sz_pkg`: `FLOAT_W`, `MODEL_LAT`, code constants `CODE_UNP`=2'b00 and `CODE_PRED`=2'b01, and a `float_is_nan_inf` function.
- Sub-module `sz_fifo`: synchronous FIFO (width and depth parameters, async active-low reset, ready/valid read port, full/empty outputs). It is reusable for other outlier streams.
- Delay line and classifier are inline in `sz_quant_select`.

## Test plan
- `err_bound`=0x3A83126F (1e-3), `err_abs`=0x3A000000, `pred`=0x3F800000 → `code`=01, `recon`=0x3F800000, FIFO unchanged, `code_valid` at in_valid+37.
- Same bound, `err_abs`=0x3A83126F (equal) then 0x7FC00000 (NaN), `data_in`=0x40490FDB → both give `code`=00, `recon`=0x40490FDB, two FIFO entries, `n_unp`=2.
- `UNP_DEPTH`=4, `unp_ready`=0, 5 unpredictable points → `overflow`=1, FIFO holds the first 4 in order, `n_unp`=5. Then `unp_ready`=1 → 4 pops, then `unp_valid`=0.
- FIFO full, one more unpredictable point with `unp_ready`=1 in the same cycle → no overflow, depth stays 4, order preserved.
- Back-to-back 100-point stream with random bound hits → `n_points`=100, codes match a reference model cycle-for-cycle. Assert `rst` at point 50 → outputs zero immediately, no stale `code_valid` after release.

Source files
------------

// File: rtl/sz_quant_select_pkg.sv
// sz_pkg: shared float width, model latency, quantiser codes and float helpers
package sz_pkg;
   localparam int FLOAT_W = 32;
   localparam int MODEL_LAT = 36;
   localparam int EXP_W = 8;
   localparam logic [1:0] CODE_UNP = 2'b00;
   localparam logic [1:0] CODE_PRED = 2'b01;
   function automatic logic float_is_nan_inf(input logic [FLOAT_W-1:0] f);
      return &f[FLOAT_W-2 -: EXP_W];
   endfunction
endpackage

// File: rtl/sz_quant_select_if.sv
// sz_quant_select_if: model-side inputs, code stream and outlier read port of the quantiser
interface sz_quant_select_if #(parameter int FLOAT_W = sz_pkg::FLOAT_W);
   logic in_valid;
   logic [FLOAT_W-1:0] data_in;
   logic [FLOAT_W-1:0] pred;
   logic [FLOAT_W-1:0] err_abs;
   logic [FLOAT_W-1:0] err_bound;
   logic code_valid;
   logic [1:0] code;
   logic [FLOAT_W-1:0] recon;
   logic unp_valid;
   logic unp_ready;
   logic [FLOAT_W-1:0] unp_data;
   logic overflow;
   logic [31:0] n_points;
   logic [31:0] n_unp;
   modport master(
      output in_valid, data_in, pred, err_abs, err_bound, unp_ready,
      input code_valid, code, recon, unp_valid, unp_data, overflow, n_points, n_unp
   );
   modport slave(
      input in_valid, data_in, pred, err_abs, err_bound, unp_ready,
      output code_valid, code, recon, unp_valid, unp_data, overflow, n_points, n_unp
   );
endinterface

// File: rtl/sz_quant_select_fifo.sv
// sz_fifo: synchronous FIFO with ready/valid read port and extra-bit full/empty pointers
module sz_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [AW:0] wr_q, wr_d, rd_q, rd_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic push, pop;
   always_comb begin
      empty = wr_q == rd_q;
      full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
      pop = !empty && rd_ready;
      push = wr_en && (!full || pop);
      wr_d = push ? wr_q + 1'b1 : wr_q;
      rd_d = pop ? rd_q + 1'b1 : rd_q;
      rd_valid = !empty;
      rd_data = empty ? '0 : mem_q[rd_q[AW-1:0]];
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end
   // storage needs no reset: the read data is masked while empty
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q[AW-1:0]] <= wr_data;
   end
endmodule

// File: rtl/sz_quant_select.sv
// sz_quant_select: aligns samples with the model output, classifies against the bound, queues outliers
module sz_quant_select #(
   parameter int FLOAT_W = sz_pkg::FLOAT_W,
   parameter int MODEL_LAT = sz_pkg::MODEL_LAT,
   parameter int UNP_DEPTH = 16
) (
   input logic clk,
   input logic rst,
   input logic clear,
   sz_quant_select_if.slave bus
);
   import sz_pkg::*;
   logic [MODEL_LAT-1:0] vld_q, vld_d;
   logic [MODEL_LAT-1:0][FLOAT_W-1:0] dat_q, dat_d;
   logic a_vld, pred_ok, push, pop, full, empty;
   logic [FLOAT_W-1:0] a_dat;
   logic code_valid_q, code_valid_d;
   logic [1:0] code_q, code_d;
   logic [FLOAT_W-1:0] recon_q, recon_d;
   logic overflow_q, overflow_d;
   logic [31:0] n_points_q, n_points_d, n_unp_q, n_unp_d;
   always_comb begin
      vld_d = {vld_q[MODEL_LAT-2:0], bus.in_valid};
      dat_d = {dat_q[MODEL_LAT-2:0], bus.data_in};
      a_vld = vld_q[MODEL_LAT-1];
      a_dat = dat_q[MODEL_LAT-1];
      // magnitude-only compare; an all-ones exponent (NaN/Inf) is never predictable
      pred_ok = (bus.err_abs[FLOAT_W-2:0] < bus.err_bound[FLOAT_W-2:0]) && !float_is_nan_inf(bus.err_abs);
      push = a_vld && !pred_ok;
      pop = !empty && bus.unp_ready;
      code_valid_d = a_vld;
      code_d = a_vld ? (pred_ok ? CODE_PRED : CODE_UNP) : code_q;
      recon_d = a_vld ? (pred_ok ? bus.pred : a_dat) : recon_q;
      overflow_d = !clear && (overflow_q || (push && full && !pop));
      n_points_d = clear ? '0 : n_points_q + {31'd0, a_vld && !(&n_points_q)};
      n_unp_d = clear ? '0 : n_unp_q + {31'd0, push && !(&n_unp_q)};
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q <= '0;
         dat_q <= '0;
         code_valid_q <= 1'b0;
         code_q <= CODE_UNP;
         recon_q <= '0;
         overflow_q <= 1'b0;
         n_points_q <= '0;
         n_unp_q <= '0;
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
         code_valid_q <= code_valid_d;
         code_q <= code_d;
         recon_q <= recon_d;
         overflow_q <= overflow_d;
         n_points_q <= n_points_d;
         n_unp_q <= n_unp_d;
      end
   end
   sz_fifo #(.WIDTH(FLOAT_W), .DEPTH(UNP_DEPTH)) u_unp_fifo (
      .clk(clk),
      .rst(rst),
      .wr_en(push),
      .wr_data(a_dat),
      .rd_valid(bus.unp_valid),
      .rd_ready(bus.unp_ready),
      .rd_data(bus.unp_data),
      .full(full),
      .empty(empty)
   );
   assign bus.code_valid = code_valid_q;
   assign bus.code = code_q;
   assign bus.recon = recon_q;
   assign bus.overflow = overflow_q;
   assign bus.n_points = n_points_q;
   assign bus.n_unp = n_unp_q;
endmodule
